// File: rtl/fir_ctrl_mk.sv
// fir_ctrl_mk: multi-channel FIR sequencer sharing one MAC across channels,
// with output backpressure, synchronous abort and configuration checking.
module fir_ctrl_mk #(
  parameter int MAX_TAPS = 32,
  parameter int MAX_PROBEK = 1024,
  parameter int N_KAN = 4,
  localparam int TW = $clog2(MAX_TAPS) + 1,
  localparam int IW = $clog2(MAX_TAPS),
  localparam int SW = $clog2(MAX_PROBEK) + 1,
  localparam int PW = $clog2(MAX_PROBEK),
  localparam int CW = $clog2(N_KAN) + 1,
  localparam int KW = (N_KAN > 1) ? $clog2(N_KAN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          START,
  input  logic          ABORT,
  input  logic [TW-1:0] cfg_taps,
  input  logic [SW-1:0] cfg_probki,
  input  logic [CW-1:0] cfg_kanaly,
  input  logic          wyj_ready,
  output logic          pracuje,
  output logic          DONE,
  output logic          BLAD,
  output logic          FSM_MUX_wej,
  output logic          FSM_MUX_wyj,
  output logic          FSM_MUX_CDC,
  output logic          FSM_zapisz_wsp,
  output logic          FSM_reset_shift,
  output logic          FSM_nowa_shift,
  output logic          FSM_Acc_en,
  output logic          FSM_reset_Acc,
  output logic          FSM_Acc_zapisz,
  output logic          FSM_wyj_wr,
  output logic [IW-1:0] tap_idx,
  output logic [PW-1:0] probka_idx,
  output logic [KW-1:0] kanal_idx
);
  typedef enum logic [3:0] {IDLE, ERR, INIT, LOAD, MAC, STORE, OUT, NEXT, KONIEC} state_t;
  state_t state_q;
  logic [IW-1:0] tap_q, tm1_q;
  logic [PW-1:0] prb_q, pm1_q;
  logic [KW-1:0] kan_q, km1_q;
  logic cfg_ok;
  assign cfg_ok = cfg_taps != '0 && cfg_taps <= TW'(MAX_TAPS) &&
                  cfg_probki != '0 && cfg_probki <= SW'(MAX_PROBEK) &&
                  cfg_kanaly != '0 && cfg_kanaly <= CW'(N_KAN);
  // Latched limits are stored as cfg-1 so every counter fits its index width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_q <= '0;
      prb_q <= '0;
      kan_q <= '0;
      tm1_q <= '0;
      pm1_q <= '0;
      km1_q <= '0;
    end else if (ABORT && state_q != IDLE && state_q != ERR) begin
      state_q <= IDLE;
      tap_q <= '0;
      prb_q <= '0;
      kan_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (START) begin
          state_q <= cfg_ok ? INIT : ERR;
          if (cfg_ok) begin
            tm1_q <= IW'(cfg_taps - TW'(1));
            pm1_q <= PW'(cfg_probki - SW'(1));
            km1_q <= KW'(cfg_kanaly - CW'(1));
          end
        end
        ERR: state_q <= IDLE;
        INIT: begin
          tap_q <= '0;
          prb_q <= '0;
          kan_q <= '0;
          state_q <= LOAD;
        end
        LOAD: begin
          tap_q <= '0;
          state_q <= MAC;
        end
        MAC: begin
          tap_q <= (tap_q == tm1_q) ? '0 : tap_q + IW'(1);
          if (tap_q == tm1_q) state_q <= STORE;
        end
        STORE: state_q <= OUT;
        OUT: if (wyj_ready) state_q <= NEXT;
        NEXT: if (kan_q != km1_q) begin
          kan_q <= kan_q + KW'(1);
          state_q <= LOAD;
        end else begin
          kan_q <= '0;
          if (prb_q != pm1_q) begin
            prb_q <= prb_q + PW'(1);
            state_q <= LOAD;
          end else state_q <= KONIEC;
        end
        KONIEC: begin
          tap_q <= '0;
          prb_q <= '0;
          kan_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pracuje = state_q != IDLE && state_q != ERR;
  assign FSM_MUX_wej = pracuje;
  assign FSM_MUX_wyj = pracuje;
  assign FSM_MUX_CDC = pracuje;
  assign DONE = state_q == KONIEC;
  assign BLAD = state_q == ERR;
  assign FSM_zapisz_wsp = state_q == INIT;
  assign FSM_reset_shift = state_q == INIT;
  assign FSM_nowa_shift = state_q == LOAD;
  assign FSM_Acc_en = state_q == MAC;
  assign FSM_reset_Acc = state_q == INIT || state_q == NEXT;
  assign FSM_Acc_zapisz = state_q == STORE;
  assign FSM_wyj_wr = state_q == OUT;
  assign tap_idx = tap_q;
  assign probka_idx = prb_q;
  assign kanal_idx = kan_q;
endmodule

// File: tb/tb_fir_ctrl_mk.sv
// tb_fir_ctrl_mk: directed bench with a per-cycle expected-trace model of fir_ctrl_mk.
module tb_fir_ctrl_mk;
  logic clk, rst_n, START, ABORT, wyj_ready;
  logic [5:0] cfg_taps;
  logic [10:0] cfg_probki;
  logic [2:0] cfg_kanaly;
  logic pracuje, DONE, BLAD, FSM_MUX_wej, FSM_MUX_wyj, FSM_MUX_CDC;
  logic FSM_zapisz_wsp, FSM_reset_shift, FSM_nowa_shift, FSM_Acc_en;
  logic FSM_reset_Acc, FSM_Acc_zapisz, FSM_wyj_wr;
  logic [4:0] tap_idx;
  logic [9:0] probka_idx;
  logic [1:0] kanal_idx;

  fir_ctrl_mk dut (
    .clk(clk), .rst_n(rst_n), .START(START), .ABORT(ABORT),
    .cfg_taps(cfg_taps), .cfg_probki(cfg_probki), .cfg_kanaly(cfg_kanaly),
    .wyj_ready(wyj_ready), .pracuje(pracuje), .DONE(DONE), .BLAD(BLAD),
    .FSM_MUX_wej(FSM_MUX_wej), .FSM_MUX_wyj(FSM_MUX_wyj), .FSM_MUX_CDC(FSM_MUX_CDC),
    .FSM_zapisz_wsp(FSM_zapisz_wsp), .FSM_reset_shift(FSM_reset_shift),
    .FSM_nowa_shift(FSM_nowa_shift), .FSM_Acc_en(FSM_Acc_en),
    .FSM_reset_Acc(FSM_reset_Acc), .FSM_Acc_zapisz(FSM_Acc_zapisz),
    .FSM_wyj_wr(FSM_wyj_wr), .tap_idx(tap_idx), .probka_idx(probka_idx),
    .kanal_idx(kanal_idx)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] ctl;
    int tap, prb, kan;
    bit chk;
  } exp_t;

  exp_t q[$];
  int xfer[$];
  int checks = 0, errors = 0;
  int pr_n = 0, acc_n = 0, done_n = 0, blad_n = 0, wr_n = 0, wrh_n = 0;
  int cyc = 0, init_cyc = 0, done_cyc = 0;
  bit en_cmp = 1;
  logic [12:0] act_ctl;
  assign act_ctl = {pracuje, FSM_MUX_wej, FSM_MUX_wyj, FSM_MUX_CDC, DONE, BLAD,
                    FSM_zapisz_wsp, FSM_reset_shift, FSM_nowa_shift, FSM_Acc_en,
                    FSM_reset_Acc, FSM_Acc_zapisz, FSM_wyj_wr};

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  // Phase codes: 0 idle, 1 err, 2 init, 3 load, 4 mac, 5 store, 6 out, 7 next, 8 koniec.
  function automatic exp_t mk(int s, int t, int p, int k, bit c);
    exp_t e;
    bit pr;
    pr = s >= 2;
    e.ctl = {pr, pr, pr, pr, s == 8, s == 1, s == 2, s == 2, s == 3, s == 4,
             (s == 2) || (s == 7), s == 5, s == 6};
    e.tap = t;
    e.prb = p;
    e.kan = k;
    e.chk = c;
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (pracuje) pr_n++;
    if (FSM_Acc_en) acc_n++;
    if (DONE) begin done_n++; done_cyc = cyc; end
    if (BLAD) blad_n++;
    if (FSM_zapisz_wsp) init_cyc = cyc;
    if (FSM_wyj_wr) wrh_n++;
    if (FSM_wyj_wr && wyj_ready) begin
      wr_n++;
      xfer.push_back(int'(probka_idx) * 8 + int'(kanal_idx));
    end
  end

  always @(negedge clk) if (en_cmp) begin
    exp_t e;
    e = mk(0, 0, 0, 0, 0);
    if (q.size() != 0) e = q.pop_front();
    chk("ctl", int'(act_ctl), int'(e.ctl));
    if (e.chk) begin
      chk("tap_idx", int'(tap_idx), e.tap);
      chk("probka_idx", int'(probka_idx), e.prb);
      chk("kanal_idx", int'(kanal_idx), e.kan);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(int t, int p, int k, int stall, int cut);
    exp_t r[$];
    cfg_taps = 6'(t);
    cfg_probki = 11'(p);
    cfg_kanaly = 3'(k);
    START = 1;
    q.push_back(mk(0, 0, 0, 0, 0));
    r.push_back(mk(2, 0, 0, 0, 0));
    for (int pp = 0; pp < p; pp++)
      for (int kk = 0; kk < k; kk++) begin
        r.push_back(mk(3, 0, pp, kk, 1));
        for (int tt = 0; tt < t; tt++) r.push_back(mk(4, tt, pp, kk, 1));
        r.push_back(mk(5, 0, pp, kk, 1));
        for (int s = 0; s <= stall; s++) r.push_back(mk(6, 0, pp, kk, 1));
        r.push_back(mk(7, 0, pp, kk, 1));
      end
    r.push_back(mk(8, 0, p - 1, 0, 1));
    for (int i = 0; i < r.size() && (cut < 0 || i < cut); i++) q.push_back(r[i]);
    if (cut >= 0) repeat (2) q.push_back(mk(0, 0, 0, 0, 1));
    tick;
    START = 0;
  endtask

  task automatic bad(int t, int p, int k);
    cfg_taps = 6'(t);
    cfg_probki = 11'(p);
    cfg_kanaly = 3'(k);
    START = 1;
    q.push_back(mk(0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0));
    tick;
    START = 0;
  endtask

  task automatic drain;
    for (int i = 0; i < 500 && q.size() != 0; i++) tick;
    chk("drain_timeout", q.size(), 0);
    tick;
    tick;
  endtask

  int s_pr, s_acc, s_done, s_blad, s_wr, s_wrh, xs;
  int exp_x[6] = '{0, 1, 2, 8, 9, 10};

  initial begin
    rst_n = 0; START = 0; ABORT = 0; wyj_ready = 1;
    cfg_taps = 0; cfg_probki = 0; cfg_kanaly = 0;
    tick;
    tick;
    chk("reset_outputs", int'(act_ctl), 0);
    chk("reset_idx", int'(tap_idx) + int'(probka_idx) + int'(kanal_idx), 0);
    rst_n = 1;
    tick;
    // T=3 P=2 K=1
    s_pr = pr_n; s_acc = acc_n; s_done = done_n; s_wr = wr_n;
    run(3, 2, 1, 0, -1);
    drain;
    chk("t1_pracuje_cycles", pr_n - s_pr, 16);
    chk("t1_acc_cycles", acc_n - s_acc, 6);
    chk("t1_done", done_n - s_done, 1);
    chk("t1_outputs", wr_n - s_wr, 2);
    chk("t1_done_offset", done_cyc - init_cyc + 1, 16);
    // T=2 P=2 K=3 interleaved channels
    s_done = done_n; s_wr = wr_n; xs = xfer.size(); s_pr = pr_n;
    run(2, 2, 3, 0, -1);
    drain;
    chk("t2_outputs", wr_n - s_wr, 6);
    chk("t2_done", done_n - s_done, 1);
    chk("t2_pracuje_cycles", pr_n - s_pr, 38);
    for (int i = 0; i < 6; i++) chk("t2_xfer_order", xfer[xs + i], exp_x[i]);
    // backpressure: ready low for first 5 OUT cycles
    s_pr = pr_n; s_done = done_n; s_wr = wr_n; s_wrh = wrh_n;
    wyj_ready = 0;
    run(1, 1, 1, 5, -1);
    repeat (9) tick;
    wyj_ready = 1;
    drain;
    chk("bp_wr_high_cycles", wrh_n - s_wrh, 6);
    chk("bp_transfers", wr_n - s_wr, 1);
    chk("bp_pracuje_cycles", pr_n - s_pr, 12);
    chk("bp_done_offset", done_cyc - init_cyc + 1, 12);
    chk("bp_done", done_n - s_done, 1);
    // configuration errors
    s_pr = pr_n; s_done = done_n; s_blad = blad_n;
    bad(0, 1, 1);
    tick;
    tick;
    bad(1, 1, 5);
    drain;
    chk("err_blad", blad_n - s_blad, 2);
    chk("err_pracuje", pr_n - s_pr, 0);
    chk("err_done", done_n - s_done, 0);
    // abort in first MAC of second output, with a stray START mid-run
    s_done = done_n;
    run(3, 2, 1, 0, 10);
    repeat (3) tick;
    START = 1;
    tick;
    START = 0;
    repeat (5) tick;
    ABORT = 1;
    tick;
    ABORT = 0;
    drain;
    chk("abort_done", done_n - s_done, 0);
    chk("abort_pracuje", int'(pracuje), 0);
    s_done = done_n;
    run(2, 1, 2, 0, -1);
    drain;
    chk("post_abort_done", done_n - s_done, 1);
    // asynchronous reset mid-MAC
    en_cmp = 0;
    run(3, 2, 1, 0, -1);
    for (int i = 0; i < 10 && !FSM_Acc_en; i++) tick;
    chk("rst_reach_mac", int'(FSM_Acc_en), 1);
    tick;
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_outputs", int'(act_ctl), 0);
    chk("async_rst_idx", int'(tap_idx) + int'(probka_idx) + int'(kanal_idx), 0);
    q.delete();
    tick;
    rst_n = 1;
    en_cmp = 1;
    tick;
    s_done = done_n;
    run(1, 1, 1, 0, -1);
    drain;
    chk("post_rst_done", done_n - s_done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_ctrl_mk.md
# fir_ctrl_mk

Parametrised multi-channel FIR controller; the next-generation sequencer for the FIR datapath. It accepts a runtime configuration of tap count, samples per channel and active channel count. It time-multiplexes one MAC datapath across channels and drives the shift register, accumulator and coefficient/sample memories with explicit indices. It adds output backpressure (valid/ready), a synchronous abort and configuration checking, and sits between the CDC/register interface and the FIR datapath.

## Interface
- MAX_TAPS, 32: maximum taps; TW = $clog2(MAX_TAPS)+1, IW = $clog2(MAX_TAPS)
- MAX_PROBEK, 1024: maximum samples per channel; SW = $clog2(MAX_PROBEK)+1, PW = $clog2(MAX_PROBEK)
- N_KAN, 4: channel count; CW = $clog2(N_KAN)+1, KW = max(1,$clog2(N_KAN))
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- START  in  1  run request; sampled only in IDLE
- ABORT  in  1  synchronous abort; sampled in every non-IDLE state
- cfg_taps  in  TW  tap count, legal 1..MAX_TAPS; latched on accepted START
- cfg_probki  in  SW  samples per channel, legal 1..MAX_PROBEK; latched
- cfg_kanaly  in  CW  active channels, legal 1..N_KAN; latched
- wyj_ready  in  1  output sink ready
- pracuje  out  1  high in every state except IDLE and ERR
- DONE  out  1  one-cycle pulse on normal completion
- BLAD  out  1  one-cycle pulse on rejected configuration
- FSM_MUX_wej / FSM_MUX_wyj / FSM_MUX_CDC  out  1 each  equal to pracuje
- FSM_zapisz_wsp, FSM_reset_shift  out  1  high in INIT only
- FSM_nowa_shift  out  1  high in LOAD: shift new sample of kanal_idx
- FSM_Acc_en  out  1  high in MAC
- FSM_reset_Acc  out  1  high in INIT and NEXT
- FSM_Acc_zapisz  out  1  high in STORE
- FSM_wyj_wr  out  1  output valid, high in OUT
- tap_idx  out  IW  coefficient/delay-line index during MAC
- probka_idx  out  PW  current sample index
- kanal_idx  out  KW  current channel

## Operation
- States: IDLE, ERR, INIT, LOAD, MAC, STORE, OUT, NEXT, KONIEC. Reset: state IDLE, all counters and registered cfg 0, all outputs 0.
- IDLE: START=1 with legal cfg goes to INIT and latches cfg. START=1 with any field 0 or above its maximum goes to ERR; cfg is not latched.
- ERR: BLAD=1; always goes to IDLE next.
- INIT: clear tap_idx/probka_idx/kanal_idx; then go to LOAD.
- LOAD: then go to MAC with tap_idx=0.
- MAC: tap_idx increments each cycle. At tap_idx = taps-1, go to STORE and clear tap_idx. Exactly `taps` MAC cycles occur per output.
- STORE: then go to OUT.
- OUT: FSM_wyj_wr held until wyj_ready=1. A transfer is FSM_wyj_wr & wyj_ready. On a transfer go to NEXT; otherwise stay, with all indices stable.
- NEXT:
  - If kanal_idx < kanaly-1: kanal_idx++.
  - Else: kanal_idx=0. If probka_idx < probki-1: probka_idx++; else go to KONIEC.
  - If not KONIEC, go to LOAD.
- Channel order is interleaved: for each sample, channels 0..kanaly-1.
- KONIEC: DONE=1; go to IDLE.
- ABORT=1 in INIT..NEXT or KONIEC: next state IDLE, counters cleared, no DONE. ABORT has priority over every other transition, including the OUT transfer (the transfer in that cycle still counts at the sink). ABORT in IDLE/ERR is ignored.
- START while not in IDLE is ignored. cfg changes after latch have no effect until the next run.
- Counter widths never overflow: comparisons use latched cfg minus 1; tap_idx max MAX_TAPS-1.

## Timing
- All outputs are decoded from registered state and counters only; there is no combinational input-to-output path.
- START at edge k: INIT in cycle k+1, LOAD in k+2, first FSM_Acc_en in k+3.
- Per output with wyj_ready tied high: LOAD + T·MAC + STORE + OUT + NEXT = T+4 cycles.
- Full run with wyj_ready high: 1 + P·K·(T+4) + 1 cycles from INIT through KONIEC.
- Each cycle wyj_ready is low in OUT adds exactly one cycle.
- Asynchronous reset mid-run returns to IDLE immediately with all outputs 0.

## Test plan
- Reset: assert rst_n=0 mid-MAC -> all outputs 0 and state IDLE at once; START afterwards runs normally.
- T=3, P=2, K=1, wyj_ready=1 -> 2 outputs; FSM_Acc_en high 3 cycles each with tap_idx 0,1,2; DONE 16 cycles after INIT entry (1+2·7+1); pracuje high for exactly 16 cycles.
- T=2, P=2, K=3 -> kanal_idx/probka_idx sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); 6 FSM_wyj_wr transfers; single DONE.
- Backpressure: T=1, P=1, K=1, wyj_ready low for 5 cycles in OUT -> FSM_wyj_wr held 6 cycles, indices stable, DONE delayed by 5.
- Config errors: START with cfg_taps=0, then with cfg_kanaly=N_KAN+1 -> BLAD one cycle each, pracuje never high, no DONE.
- ABORT asserted in MAC of the second output; START pulse while busy -> next cycle IDLE, no DONE, indices 0; the mid-run START has no effect; a new START then completes normally.
